// File: rtl/tboom_checkpoint_ctrl_if.sv
// Dispatch / branch-unit / freelist signals of the checkpoint controller.
// The master side is the dispatch and branch logic; the slave side is the controller.
interface tboom_checkpoint_ctrl_if #(
    parameter int CHECKPOINT_DEPTH = 8
);
    localparam int TAG_W = $clog2(CHECKPOINT_DEPTH);

    logic             br_req;
    logic             br_gnt;
    logic [TAG_W-1:0] br_tag;
    logic             resolve_valid;
    logic [TAG_W-1:0] resolve_tag;
    logic             resolve_mispredict;
    logic             fl_checkpoint;
    logic             fl_restore;
    logic [TAG_W-1:0] fl_pos;
    logic             dispatch_stall;
    logic             ckpt_full;
    logic [TAG_W:0]   ckpt_count;
    logic             invalid_resolve;

    modport master (
        output br_req, resolve_valid, resolve_tag, resolve_mispredict,
        input  br_gnt, br_tag, fl_checkpoint, fl_restore, fl_pos,
               dispatch_stall, ckpt_full, ckpt_count, invalid_resolve
    );

    modport slave (
        input  br_req, resolve_valid, resolve_tag, resolve_mispredict,
        output br_gnt, br_tag, fl_checkpoint, fl_restore, fl_pos,
               dispatch_stall, ckpt_full, ckpt_count, invalid_resolve
    );
endinterface

// File: rtl/tboom_checkpoint_ctrl.sv
// Checkpoint slot (branch tag) allocator for the rename freelist: in-order ring
// allocation, free on correct resolve, kill-younger plus one-cycle restore on mispredict.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | normal operation: allocate, free, accept mispredicts
// RESTORE | freelist restore to restore_tag this cycle; no allocation
module tboom_checkpoint_ctrl #(
    parameter int CHECKPOINT_DEPTH = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    tboom_checkpoint_ctrl_if.slave bus
);
    localparam int TAG_W = $clog2(CHECKPOINT_DEPTH);

    typedef enum logic {IDLE, RESTORE} state_t;

    state_t                      state, state_next;
    logic [CHECKPOINT_DEPTH-1:0] valid, valid_next, kill_mask;
    logic [TAG_W-1:0]            tail, tail_next;
    logic [TAG_W-1:0]            restore_tag, restore_tag_next;
    logic [TAG_W-1:0]            span;
    logic [TAG_W:0]              count, count_next;
    logic                        invalid, invalid_next;
    logic                        mispredict, full, grant;

    assign mispredict = bus.resolve_valid & bus.resolve_mispredict;
    assign full       = valid[tail];
    assign grant      = bus.br_req & ~full & (state == IDLE) & ~mispredict;

    // Slots from the mispredicted tag up to (not including) tail, walking the ring.
    // A valid tag equal to tail means the ring is full and everything dies.
    always_comb begin
        span      = tail - bus.resolve_tag;
        kill_mask = '0;
        for (int i = 0; i < CHECKPOINT_DEPTH; i++) begin
            kill_mask[i] = (span == '0) || ((TAG_W'(i) - bus.resolve_tag) < span);
        end
    end

    always_comb begin
        state_next       = state;
        valid_next       = valid;
        tail_next        = tail;
        restore_tag_next = restore_tag;
        invalid_next     = invalid;

        if (state == RESTORE) begin
            state_next = IDLE;
        end

        if (bus.resolve_valid) begin
            if (!valid[bus.resolve_tag]) begin
                invalid_next = 1'b1;
            end else if (!bus.resolve_mispredict) begin
                valid_next[bus.resolve_tag] = 1'b0;
            end else if (state == RESTORE) begin
                invalid_next = 1'b1;
            end else begin
                valid_next       = valid & ~kill_mask;
                tail_next        = bus.resolve_tag;
                restore_tag_next = bus.resolve_tag;
                state_next       = RESTORE;
            end
        end

        // A grant never coincides with a mispredict, and the granted slot is
        // free, so it cannot collide with a correct resolve.
        if (grant) begin
            valid_next[tail] = 1'b1;
            tail_next        = tail + TAG_W'(1);
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < CHECKPOINT_DEPTH; i++) begin
            count_next = count_next + (TAG_W+1)'(valid_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            valid       <= '0;
            tail        <= '0;
            restore_tag <= '0;
            count       <= '0;
            invalid     <= 1'b0;
        end else begin
            state       <= state_next;
            valid       <= valid_next;
            tail        <= tail_next;
            restore_tag <= restore_tag_next;
            count       <= count_next;
            invalid     <= invalid_next;
        end
    end

    assign bus.br_gnt          = grant;
    assign bus.br_tag          = tail;
    assign bus.fl_checkpoint   = grant;
    assign bus.fl_restore      = (state == RESTORE);
    assign bus.fl_pos          = (state == RESTORE) ? restore_tag : tail;
    assign bus.dispatch_stall  = (full & bus.br_req) | mispredict | (state == RESTORE);
    assign bus.ckpt_full       = full;
    assign bus.ckpt_count      = count;
    assign bus.invalid_resolve = invalid;
endmodule

// File: tb/tb_tboom_checkpoint_ctrl.sv
// Bench for tboom_checkpoint_ctrl: queue-based program-order model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_tboom_checkpoint_ctrl;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tboom_checkpoint_ctrl_if #(.CHECKPOINT_DEPTH(D)) bus ();

    tboom_checkpoint_ctrl #(.CHECKPOINT_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: in-flight tags in program order, next tag, pending restore.
    logic [2:0] m_q[$];
    logic [2:0] m_tail;
    logic [2:0] m_rtag;
    logic       m_restore;
    logic       m_inv;
    logic       m_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : model_cmp
        logic full, mis, gnt, nxt_restore;
        int   idx;
        full = 1'b0;
        for (int k = 0; k < m_q.size(); k++) if (m_q[k] == m_tail) full = 1'b1;
        mis = bus.resolve_valid && bus.resolve_mispredict;
        gnt = bus.br_req && !full && !m_restore && !mis;
        if (m_live) begin
            chk("m_br_gnt",   32'(bus.br_gnt),          32'(gnt));
            chk("m_br_tag",   32'(bus.br_tag),          32'(m_tail));
            chk("m_fl_ckpt",  32'(bus.fl_checkpoint),   32'(gnt));
            chk("m_fl_rest",  32'(bus.fl_restore),      32'(m_restore));
            chk("m_fl_pos",   32'(bus.fl_pos),          32'(m_restore ? m_rtag : m_tail));
            chk("m_stall",    32'(bus.dispatch_stall),  32'((full && bus.br_req) || mis || m_restore));
            chk("m_full",     32'(bus.ckpt_full),       32'(full));
            chk("m_count",    32'(bus.ckpt_count),      32'(m_q.size()));
            chk("m_invalid",  32'(bus.invalid_resolve), 32'(m_inv));
        end
        if (!rst_n) begin
            m_q.delete();
            m_tail = '0; m_rtag = '0; m_restore = 1'b0; m_inv = 1'b0;
            m_live = 1'b1;
        end else begin
            nxt_restore = 1'b0;
            if (bus.resolve_valid) begin
                idx = -1;
                for (int k = 0; k < m_q.size(); k++) if (m_q[k] == bus.resolve_tag) idx = k;
                if (idx < 0) m_inv = 1'b1;
                else if (!bus.resolve_mispredict) m_q.delete(idx);
                else if (m_restore) m_inv = 1'b1;
                else begin
                    while (m_q.size() > idx) void'(m_q.pop_back());
                    m_tail = bus.resolve_tag;
                    m_rtag = bus.resolve_tag;
                    nxt_restore = 1'b1;
                end
            end
            if (gnt) begin
                m_q.push_back(m_tail);
                m_tail = m_tail + 3'd1;
            end
            m_restore = nxt_restore;
        end
    end

    task automatic set_in(input logic r, input logic rv, input logic [2:0] rt, input logic rm);
        bus.br_req = r;
        bus.resolve_valid = rv;
        bus.resolve_tag = rt;
        bus.resolve_mispredict = rm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, "_count"},   32'(bus.ckpt_count),      0);
        chk({tagname, "_fl_pos"},  32'(bus.fl_pos),          0);
        chk({tagname, "_fl_rest"}, 32'(bus.fl_restore),      0);
        chk({tagname, "_invalid"}, 32'(bus.invalid_resolve), 0);
        chk({tagname, "_full"},    32'(bus.ckpt_full),       0);
        chk({tagname, "_stall"},   32'(bus.dispatch_stall),  0);
        chk({tagname, "_gnt"},     32'(bus.br_gnt),          0);
        chk({tagname, "_ckpt"},    32'(bus.fl_checkpoint),   0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        step(); step();
        neg();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Fill all eight slots in order, then one request too many.
        for (int i = 0; i < D; i++) begin
            set_in(1, 0, 0, 0);
            neg();
            chk("fill_gnt",  32'(bus.br_gnt), 1);
            chk("fill_tag",  32'(bus.br_tag), 32'(i));
            chk("fill_pos",  32'(bus.fl_pos), 32'(i));
            chk("fill_ckpt", 32'(bus.fl_checkpoint), 1);
            step();
        end
        set_in(1, 0, 0, 0);
        neg();
        chk("full_gnt",   32'(bus.br_gnt), 0);
        chk("full_flag",  32'(bus.ckpt_full), 1);
        chk("full_count", 32'(bus.ckpt_count), 8);
        chk("full_stall", 32'(bus.dispatch_stall), 1);
        step();

        // Free the tail slot while requesting: grant only next cycle, tail wraps.
        set_in(1, 1, 0, 0);
        neg();
        chk("free_tail_nogrant", 32'(bus.br_gnt), 0);
        step();
        set_in(1, 0, 0, 0);
        neg();
        chk("regrant_gnt",   32'(bus.br_gnt), 1);
        chk("regrant_tag",   32'(bus.br_tag), 0);
        chk("regrant_count", 32'(bus.ckpt_count), 7);
        step();
        set_in(0, 0, 0, 0);
        neg();
        chk("wrap_pos",  32'(bus.fl_pos), 1);
        chk("wrap_full", 32'(bus.ckpt_full), 1);
        step();

        // Fresh start: allocate 0..5, mispredict 2.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 0, 0);
            neg();
            chk("alloc6_tag", 32'(bus.br_tag), 32'(i));
            step();
        end
        set_in(1, 1, 2, 1);
        neg();
        chk("mis_suppress_gnt", 32'(bus.br_gnt), 0);
        chk("mis_stall",        32'(bus.dispatch_stall), 1);
        step();
        set_in(1, 0, 0, 0);
        neg();
        chk("rest_flag",  32'(bus.fl_restore), 1);
        chk("rest_pos",   32'(bus.fl_pos), 2);
        chk("rest_count", 32'(bus.ckpt_count), 2);
        chk("rest_gnt",   32'(bus.br_gnt), 0);
        step();
        neg();
        chk("post_rest_gnt", 32'(bus.br_gnt), 1);
        chk("post_rest_tag", 32'(bus.br_tag), 2);
        chk("post_rest_fl",  32'(bus.fl_restore), 0);
        step();
        neg();
        chk("alloc3_tag", 32'(bus.br_tag), 3);
        step();

        // Out-of-order correct resolve of 1, then mispredict the oldest (0).
        set_in(0, 1, 1, 0);
        step();
        set_in(0, 1, 0, 1);
        neg();
        chk("ooo_count", 32'(bus.ckpt_count), 3);
        step();
        set_in(0, 0, 0, 0);
        neg();
        chk("killall_rest", 32'(bus.fl_restore), 1);
        chk("killall_pos",  32'(bus.fl_pos), 0);
        chk("killall_cnt",  32'(bus.ckpt_count), 0);
        step();
        neg();
        chk("killall_tail", 32'(bus.fl_pos), 0);
        chk("killall_inv",  32'(bus.invalid_resolve), 0);
        step();

        // Resolve of a non-valid tag: sticky flag, nothing else moves.
        set_in(0, 1, 4, 0);
        step();
        set_in(0, 0, 0, 0);
        neg();
        chk("inv_set",   32'(bus.invalid_resolve), 1);
        chk("inv_count", 32'(bus.ckpt_count), 0);
        chk("inv_tail",  32'(bus.br_tag), 0);
        step();
        neg();
        chk("inv_sticky", 32'(bus.invalid_resolve), 1);
        step();

        // Grant and correct resolve of another slot in the same cycle.
        set_in(1, 0, 0, 0);
        step(); step();
        set_in(1, 1, 0, 0);
        neg();
        chk("both_gnt", 32'(bus.br_gnt), 1);
        chk("both_tag", 32'(bus.br_tag), 2);
        step();
        set_in(0, 0, 0, 0);
        neg();
        chk("both_count", 32'(bus.ckpt_count), 2);
        step();

        // Mispredict 1, then reset in the middle of RESTORE.
        set_in(0, 1, 1, 1);
        step();
        set_in(0, 0, 0, 0);
        rst_n = 1'b0;
        neg();
        chk("midrest_flag", 32'(bus.fl_restore), 1);
        chk("midrest_pos",  32'(bus.fl_pos), 1);
        step();
        rst_n = 1'b1;
        neg();
        chk_reset_outputs("midrest_reset");
        step();

        // Pseudo-random traffic checked by the model alone.
        for (int n = 0; n < 300; n++) begin
            set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4),
                   3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
            step();
        end
        set_in(0, 0, 0, 0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
